// File: rtl/vending_machine_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vending_machine_ctrl_pkg
//  Description : Shared definitions for the vending machine controller:
//                default dimensions, coin value / item price tables and the
//                sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vending_machine_ctrl_pkg;

  localparam int NUM_COINS          = 3;
  localparam int NUM_ITEMS          = 4;
  localparam int DEFAULT_TOTAL_BITS = 31;
  localparam int DEFAULT_WAIT_TIME  = 10;

  // Coin values. The greedy change picker does not rely on the table order.
  localparam int unsigned c_coin_value [NUM_COINS] = '{100, 500, 1000};

  // Item prices, indexed by the select bit position.
  localparam int unsigned c_item_price [NUM_ITEMS] = '{400, 500, 1000, 2000};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

endpackage : vending_machine_ctrl_pkg
`default_nettype wire

// File: rtl/vending_machine_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : vending_machine_ctrl_if
//  Description : Front-panel / actuator bundle of the vending machine
//                controller. The master modport is the panel side (drives
//                coins, selections and return requests); the slave modport is
//                the controller.
//  Ports       : i_input_coin, i_select_item, i_trigger_return (panel -> ctrl)
//                o_available_item, o_output_item, o_return_coin,
//                o_coin_reject, o_current_total, o_busy      (ctrl -> panel)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vending_machine_ctrl_if
  import vending_machine_ctrl_pkg::*;
#(
  parameter int TOTAL_BITS = DEFAULT_TOTAL_BITS
);

  logic [NUM_COINS-1:0]  i_input_coin;
  logic [NUM_ITEMS-1:0]  i_select_item;
  logic                  i_trigger_return;
  logic [NUM_ITEMS-1:0]  o_available_item;
  logic [NUM_ITEMS-1:0]  o_output_item;
  logic [NUM_COINS-1:0]  o_return_coin;
  logic                  o_coin_reject;
  logic [TOTAL_BITS-1:0] o_current_total;
  logic                  o_busy;

  modport master (
    output i_input_coin, i_select_item, i_trigger_return,
    input  o_available_item, o_output_item, o_return_coin,
    input  o_coin_reject, o_current_total, o_busy
  );

  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return,
    output o_available_item, o_output_item, o_return_coin,
    output o_coin_reject, o_current_total, o_busy
  );

endinterface : vending_machine_ctrl_if
`default_nettype wire

// File: rtl/vending_machine_ctrl_change_picker.sv
`default_nettype none
// ============================================================================
//  Module      : vending_machine_ctrl_change_picker
//  Description : Combinational greedy change selector. Picks the largest coin
//                whose value does not exceed the current credit.
//  Ports       : i_total        - current credit
//                o_coin_onehot  - one-hot coin to return (0 if none fits)
//                o_coin_value   - value of that coin (0 if none fits)
//  Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_ctrl_change_picker
  import vending_machine_ctrl_pkg::*;
#(
  parameter int TOTAL_BITS = DEFAULT_TOTAL_BITS
) (
  input  logic [TOTAL_BITS-1:0] i_total,
  output logic [NUM_COINS-1:0]  o_coin_onehot,
  output logic [TOTAL_BITS-1:0] o_coin_value
);

  // Scan every denomination and keep the biggest one that fits. A value that
  // truncates to zero never beats the zero starting point, so it is skipped.
  always_comb begin
    o_coin_onehot = '0;
    o_coin_value  = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if ((TOTAL_BITS'(c_coin_value[i]) <= i_total) &&
          (TOTAL_BITS'(c_coin_value[i]) >  o_coin_value)) begin
        o_coin_onehot    = '0;
        o_coin_onehot[i] = 1'b1;
        o_coin_value     = TOTAL_BITS'(c_coin_value[i]);
      end
    end
  end

endmodule : vending_machine_ctrl_change_picker
`default_nettype wire

// File: rtl/vending_machine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vending_machine_ctrl
//  Description : Transaction sequencer of the vending machine. Owns the credit
//                register and the inactivity timer and runs the
//                IDLE / ACTIVE / RETURN state machine: accepts coins (refusing
//                a whole cycle's coins on overflow), dispenses affordable
//                selections, and drains change one greedy coin per cycle.
//  Ports       : clk     - system clock, rising edge
//                reset_n - asynchronous active-low reset
//                bus     - vending_machine_ctrl_if.slave (panel/actuators)
//  Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_ctrl
  import vending_machine_ctrl_pkg::*;
#(
  parameter int TOTAL_BITS = DEFAULT_TOTAL_BITS,  // must match the interface
  parameter int WAIT_TIME  = DEFAULT_WAIT_TIME
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vending_machine_ctrl_if.slave  bus
);

  // Two spare bits hold total + the largest possible coin sum without loss.
  localparam int c_ext_bits   = TOTAL_BITS + 2;
  localparam int c_timer_bits = $clog2(WAIT_TIME + 1);
  localparam logic [c_timer_bits-1:0] c_timer_load = c_timer_bits'(WAIT_TIME);
  localparam logic [c_timer_bits-1:0] c_timer_one  = c_timer_bits'(1);

  state_t                  r_state, w_state_next;
  logic [TOTAL_BITS-1:0]   r_total, w_total_next;
  logic [c_timer_bits-1:0] r_timer, w_timer_next;
  logic [NUM_ITEMS-1:0]    r_output_item, w_output_item_next;
  logic [NUM_COINS-1:0]    r_return_coin, w_return_coin_next;
  logic                    r_coin_reject;

  logic [c_ext_bits-1:0]   w_coin_sum;
  logic [c_ext_bits-1:0]   w_sum_ext;
  logic                    w_coin_overflow;
  logic                    w_coin_ok;
  logic [TOTAL_BITS-1:0]   w_total_plus;

  logic                    w_sel_valid;
  logic [NUM_ITEMS-1:0]    w_sel_onehot;
  logic [TOTAL_BITS-1:0]   w_sel_price;
  logic                    w_dispense;
  logic [TOTAL_BITS-1:0]   w_total_after_sale;

  logic [NUM_COINS-1:0]    w_pick_onehot;
  logic [TOTAL_BITS-1:0]   w_pick_value;
  logic [TOTAL_BITS-1:0]   w_drain;
  logic [TOTAL_BITS-1:0]   w_total_after_drain;

  // --------------------------------------------------------------------------
  // Coin acceptance: the cycle's coins are taken all together or not at all.
  // --------------------------------------------------------------------------
  always_comb begin
    w_coin_sum = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (bus.i_input_coin[i]) begin
        w_coin_sum = w_coin_sum + c_ext_bits'(TOTAL_BITS'(c_coin_value[i]));
      end
    end
  end

  assign w_sum_ext       = {2'b00, r_total} + w_coin_sum;
  assign w_coin_overflow = |w_sum_ext[c_ext_bits-1:TOTAL_BITS];
  assign w_coin_ok       = (|bus.i_input_coin) && !w_coin_overflow;
  assign w_total_plus    = w_coin_ok ? w_sum_ext[TOTAL_BITS-1:0] : r_total;

  // --------------------------------------------------------------------------
  // Selection: lowest set bit wins; affordability is judged on the credit
  // held before this cycle's coins, so a coin cannot fund its own purchase.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_onehot = '0;
    w_sel_price  = '0;
    for (int j = NUM_ITEMS - 1; j >= 0; j--) begin
      if (bus.i_select_item[j]) begin
        w_sel_valid     = 1'b1;
        w_sel_onehot    = '0;
        w_sel_onehot[j] = 1'b1;
        w_sel_price     = TOTAL_BITS'(c_item_price[j]);
      end
    end
  end

  assign w_dispense         = w_sel_valid && (w_sel_price <= r_total);
  assign w_total_after_sale = w_total_plus - w_sel_price;

  // --------------------------------------------------------------------------
  // Change drain: greedy coin, or clear a residue too small for any coin.
  // --------------------------------------------------------------------------
  vending_machine_ctrl_change_picker #(
    .TOTAL_BITS (TOTAL_BITS)
  ) u_change_picker (
    .i_total       (r_total),
    .o_coin_onehot (w_pick_onehot),
    .o_coin_value  (w_pick_value)
  );

  assign w_drain             = (|w_pick_onehot) ? w_pick_value : r_total;
  assign w_total_after_drain = w_total_plus - w_drain;

  // --------------------------------------------------------------------------
  // State machine: next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_total_next       = r_total;
    w_timer_next       = r_timer;
    w_output_item_next = '0;
    w_return_coin_next = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_coin_ok) begin
          w_total_next = w_total_plus;
          w_timer_next = c_timer_load;
          w_state_next = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        w_total_next = w_total_plus;
        if (bus.i_trigger_return) begin
          // Return request outranks a dispense in the same cycle.
          w_timer_next = '0;
          w_state_next = ST_RETURN;
        end else if (w_dispense) begin
          w_output_item_next = w_sel_onehot;
          w_total_next       = w_total_after_sale;
          w_timer_next       = c_timer_load;
          if (w_total_after_sale == '0) begin
            w_timer_next = '0;
            w_state_next = ST_IDLE;
          end
        end else if (w_coin_ok) begin
          w_timer_next = c_timer_load;
        end else if (r_timer <= c_timer_one) begin
          w_timer_next = '0;
          w_state_next = ST_RETURN;
        end else begin
          w_timer_next = r_timer - c_timer_one;
        end
      end

      ST_RETURN: begin
        if (r_total == '0) begin
          // Coins arriving just as the drain finishes keep us draining.
          if (w_coin_ok) begin
            w_total_next = w_total_plus;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_return_coin_next = w_pick_onehot;
          w_total_next       = w_total_after_drain;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_total_next = '0;
        w_timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_total       <= '0;
      r_timer       <= '0;
      r_output_item <= '0;
      r_return_coin <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_total       <= w_total_next;
      r_timer       <= w_timer_next;
      r_output_item <= w_output_item_next;
      r_return_coin <= w_return_coin_next;
      r_coin_reject <= (|bus.i_input_coin) && w_coin_overflow;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < NUM_ITEMS; j++) begin : g_available
    localparam logic [TOTAL_BITS-1:0] c_price = TOTAL_BITS'(c_item_price[j]);
    assign bus.o_available_item[j] = (r_state != ST_RETURN) && (c_price <= r_total);
  end

  assign bus.o_output_item   = r_output_item;
  assign bus.o_return_coin   = r_return_coin;
  assign bus.o_coin_reject   = r_coin_reject;
  assign bus.o_current_total = r_total;
  assign bus.o_busy          = (r_state == ST_RETURN);

endmodule : vending_machine_ctrl
`default_nettype wire

// File: tb/tb_vending_machine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vending_machine_ctrl
//  Description : Self-checking bench for vending_machine_ctrl. A credit-level
//                reference model predicts every cycle's outputs into a
//                scoreboard queue; a negedge monitor pops and compares.
//                The DUT runs with a 12-bit credit so overflow is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_ctrl;

  localparam int     TB_BITS = 12;
  localparam int     TB_WAIT = 10;
  localparam longint MAX_CREDIT = (longint'(1) << TB_BITS) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_DRAIN  = 2;

  typedef struct {
    int                 cyc;
    logic [3:0]         item;
    logic [2:0]         coin;
    logic               rej;
    logic [TB_BITS-1:0] total;
    logic               busy;
    logic [3:0]         avail;
  } snap_t;

  int unsigned coin_val [3] = '{100, 500, 1000};
  int unsigned price    [4] = '{400, 500, 1000, 2000};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  snap_t  q[$];
  snap_t  mon_snap;
  int     m_mode;
  longint m_credit;
  int     m_quiet;

  vending_machine_ctrl_if #(.TOTAL_BITS(TB_BITS)) bus ();

  vending_machine_ctrl #(
    .TOTAL_BITS (TB_BITS),
    .WAIT_TIME  (TB_WAIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: credit as a plain integer, inactivity as a count of
  // consecutive quiet cycles, change as "largest coin that fits".
  task automatic model_reset();
    m_mode   = M_IDLE;
    m_credit = 0;
    m_quiet  = 0;
  endtask

  task automatic model_step(input logic [2:0] coin, input logic [3:0] sel, input logic trig);
    longint sum, after_coin, best, drained;
    bit     accept, reject;
    int     pick, best_idx;
    snap_t  s;
    s.item = '0;
    s.coin = '0;
    sum = 0;
    for (int i = 0; i < 3; i++) if (coin[i]) sum += coin_val[i];
    accept = (coin != 0) && (m_credit + sum <= MAX_CREDIT);
    reject = (coin != 0) && !accept;
    after_coin = m_credit + (accept ? sum : 0);
    case (m_mode)
      M_IDLE: begin
        if (accept) begin
          m_credit = after_coin;
          m_mode   = M_ACTIVE;
          m_quiet  = 0;
        end
      end
      M_ACTIVE: begin
        pick = -1;
        for (int j = 3; j >= 0; j--) if (sel[j]) pick = j;
        if (trig) begin
          m_credit = after_coin;
          m_mode   = M_DRAIN;
        end else if (pick >= 0 && price[pick] <= m_credit) begin
          s.item[pick] = 1'b1;
          m_credit = after_coin - price[pick];
          m_quiet  = 0;
          if (m_credit == 0) m_mode = M_IDLE;
        end else if (accept) begin
          m_credit = after_coin;
          m_quiet  = 0;
        end else begin
          m_quiet++;
          if (m_quiet >= TB_WAIT) m_mode = M_DRAIN;
        end
      end
      default: begin
        if (m_credit == 0) begin
          if (accept) m_credit = after_coin;
          else        m_mode   = M_IDLE;
        end else begin
          best = 0;
          best_idx = 0;
          for (int i = 0; i < 3; i++) begin
            if (coin_val[i] <= m_credit && coin_val[i] > best) begin
              best = coin_val[i];
              best_idx = i;
            end
          end
          if (best > 0) begin
            s.coin[best_idx] = 1'b1;
            drained = best;
          end else begin
            drained = m_credit;
          end
          m_credit = after_coin - drained;
        end
      end
    endcase
    s.cyc   = cyc + 1;
    s.rej   = reject;
    s.total = m_credit[TB_BITS-1:0];
    s.busy  = (m_mode == M_DRAIN);
    for (int j = 0; j < 4; j++) s.avail[j] = !s.busy && (price[j] <= m_credit);
    q.push_back(s);
  endtask

  // Called at 1 time unit after a rising edge; returns at the same point of
  // the next cycle, when the response to these inputs is visible.
  task automatic drive(input logic [2:0] coin, input logic [3:0] sel, input logic trig);
    bus.i_input_coin     = coin;
    bus.i_select_item    = sel;
    bus.i_trigger_return = trig;
    model_step(coin, sel, trig);
    @(posedge clk);
    #1;
    bus.i_input_coin     = '0;
    bus.i_select_item    = '0;
    bus.i_trigger_return = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(3'b000, 4'b0000, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_output_item"},   bus.o_output_item,    0);
    check({tag, "_return_coin"},   bus.o_return_coin,    0);
    check({tag, "_coin_reject"},   bus.o_coin_reject,    0);
    check({tag, "_total"},         bus.o_current_total,  0);
    check({tag, "_busy"},          bus.o_busy,           0);
    check({tag, "_available"},     bus.o_available_item, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_snap = q.pop_front();
      check("sb_output_item", bus.o_output_item,    mon_snap.item);
      check("sb_return_coin", bus.o_return_coin,    mon_snap.coin);
      check("sb_coin_reject", bus.o_coin_reject,    mon_snap.rej);
      check("sb_total",       bus.o_current_total,  mon_snap.total);
      check("sb_busy",        bus.o_busy,           mon_snap.busy);
      check("sb_available",   bus.o_available_item, mon_snap.avail);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_rc [3];
    logic [2:0] rc;
    logic [3:0] sl;
    logic       tg;
    exp_rc = '{3'b100, 3'b010, 3'b001};

    bus.i_input_coin     = '0;
    bus.i_select_item    = '0;
    bus.i_trigger_return = 1'b0;
    model_reset();

    #12;
    check_all_zero("reset");
    #11 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Timeout after inserting 1000 -> single 1000 returned.
    drive(3'b100, 4'b0000, 1'b0);
    idle(14);
    check("timeout_total", bus.o_current_total, 0);
    check("timeout_busy",  bus.o_busy, 0);

    // 500+100 then item0 (400).
    drive(3'b011, 4'b0000, 1'b0);
    drive(3'b000, 4'b0001, 1'b0);
    check("buy0_item",  bus.o_output_item, 4'b0001);
    check("buy0_total", bus.o_current_total, 200);
    drive(3'b000, 4'b0000, 1'b1);
    idle(5);

    // Unaffordable select with 300.
    for (int k = 0; k < 3; k++) drive(3'b001, 4'b0000, 1'b0);
    drive(3'b000, 4'b0001, 1'b0);
    check("poor_item",  bus.o_output_item, 0);
    check("poor_total", bus.o_current_total, 300);
    idle(16);

    // 1600 then return: 1000, 500, 100.
    drive(3'b111, 4'b0000, 1'b0);
    drive(3'b000, 4'b0000, 1'b1);
    check("ret_busy_first", bus.o_busy, 1);
    check("ret_no_coin_yet", bus.o_return_coin, 0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check($sformatf("ret_pulse%0d", k), bus.o_return_coin, exp_rc[k]);
      check($sformatf("ret_busy%0d", k),  bus.o_busy, 1);
    end
    idle(1);
    check("ret_done_busy",  bus.o_busy, 0);
    check("ret_done_total", bus.o_current_total, 0);

    // Multi-select and coin-with-dispense.
    drive(3'b100, 4'b0000, 1'b0);
    drive(3'b000, 4'b0011, 1'b0);
    check("multi_item",  bus.o_output_item, 4'b0001);
    check("multi_total", bus.o_current_total, 600);
    for (int k = 0; k < 4; k++) drive(3'b001, 4'b0000, 1'b0);
    drive(3'b100, 4'b0100, 1'b0);
    check("coinbuy_item",  bus.o_output_item, 4'b0100);
    check("coinbuy_total", bus.o_current_total, 1000);
    drive(3'b000, 4'b0000, 1'b1);
    idle(4);

    // Reset in the middle of a drain.
    drive(3'b111, 4'b0000, 1'b0);
    drive(3'b000, 4'b0000, 1'b1);
    idle(1);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    model_reset();
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("postreset_busy",  bus.o_busy, 0);
    check("postreset_total", bus.o_current_total, 0);

    // Near-max credit: 4000 + 100 exceeds 4095.
    for (int k = 0; k < 4; k++) drive(3'b100, 4'b0000, 1'b0);
    drive(3'b001, 4'b0000, 1'b0);
    check("ovf_reject", bus.o_coin_reject, 1);
    check("ovf_total",  bus.o_current_total, 4000);
    drive(3'b000, 4'b0000, 1'b1);
    idle(6);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      rc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      sl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      tg = ($urandom_range(0, 29) == 0);
      drive(rc, sl, tg);
    end
    idle(30);

    @(negedge clk);
    #1;
    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vending_machine_ctrl
`default_nettype wire
